piece_mover: RTL and testbench
==============================

Name: piece_mover

Overview:
- Parametrised next-generation falling-piece motion controller for the Tetris playfield.
- Owns the active piece's pixel position and handles gravity, key-driven lateral shift with auto-repeat, soft drop and hard drop.
- Uses board-supplied collision flags and hands the landed position to the board logic through a valid/ready lock handshake.
- Sits between the keyboard decoder / game FSM and the board/score logic.

Parameters:
CELL, 16, pixel size of one grid cell; all steps are CELL.
X_MIN, 250, leftmost playfield pixel.
X_MAX, 410, rightmost playfield pixel (exclusive edge for shape right side).
Y_MAX, 420, bottom playfield pixel.
X_START, 298, spawn x.
Y_START, 100, spawn y.
CNT_W, 28, width of all tick counters.
BASE_PERIOD, 28'h1FFFFFF, gravity period at level 0, in decis_clk cycles.
LEVEL_STEP, 28'h0300000, gravity period reduction per level.
MIN_PERIOD, 28'h04FFFFF, gravity period floor.
SOFT_PERIOD, 28'h03FFFFF, gravity period while soft drop held.
HARD_PERIOD, 28'h00FFFFF, step period during hard drop.
DAS_DELAY, 28'h0FFFFFF, hold time before lateral auto-repeat starts.
SHIFT_PERIOD, 28'h00FFFFF, lateral auto-repeat period.

Ports:
Reset  in  1  asynchronous, active-high reset
decis_clk  in  1  clock
game_run  in  1  1 = gameplay state; 0 freezes all counters and motion
spawn  in  1  one-cycle pulse: place new piece at start, enter FALL
keypress  in  3  0 none, 1 left, 2 right, 3 soft drop, 4 hard drop
level  in  4  current level
shape_size_x  in  10  piece width in pixels
shape_size_y  in  10  piece height in pixels
block_left  in  1  board: cell left of piece occupied
block_right  in  1  board: cell right of piece occupied
block_down  in  1  board: cell below piece occupied
lock_ready  in  1  board accepts lock
shape_x  out  10  piece x
shape_y  out  10  piece y
lock_valid  out  1  landed position valid; held until lock_ready
touchdown  out  1  one-cycle pulse on the cycle lock_valid && lock_ready

Behaviour:
- Reset: shape_x=X_START, shape_y=Y_START, lock_valid=0, touchdown=0, all counters 0, state IDLE.
- States: IDLE, FALL, HARD, LOCK.
  - IDLE -> FALL on spawn.
  - FALL -> HARD on press edge of key 4.
  - FALL/HARD -> LOCK when a step down is due and (block_down or shape_y+shape_size_y+CELL > Y_MAX).
  - LOCK -> IDLE when lock_ready.
- spawn in any state: position reset to start, counters cleared, lock_valid cleared, state FALL. spawn has priority over every other event in the same cycle.
- Gravity period: max(BASE_PERIOD - level*LEVEL_STEP, MIN_PERIOD), computed in CNT_W+4 bits with no wrap. If key 3 is held, use min(period, SOFT_PERIOD).
- Gravity counter: counts decis_clk cycles in FALL. When count == period-1, the counter clears and the piece steps down by CELL or goes to LOCK.
- HARD: steps every HARD_PERIOD cycles; keys are ignored.
- Lateral moves:
  - A key 1/2 press edge (keypress changes to 1 or 2) moves the piece one CELL immediately on the next cycle.
  - While the same key is held, after DAS_DELAY cycles the piece moves again every SHIFT_PERIOD cycles.
  - Releasing or changing the key clears the DAS counter.
  - Left is blocked if block_left or shape_x-CELL < X_MIN. Right is blocked if block_right or shape_x+shape_size_x+CELL > X_MAX.
  - A blocked move is dropped; the repeat timer continues.
- Clamp: if shape_x+shape_size_x > X_MAX (shape grew after rotation), shape_x = X_MAX-shape_size_x that cycle, overriding any lateral move.
- Same-cycle lateral move and gravity step: both apply. The board recomputes collision flags before the next due step.
- game_run=0: state, position and counters hold; lock_valid holds.
- Lock and lateral moves occur only in FALL.

Optional Feature:
- Macro LOCK_DELAY_EN adds parameter LOCK_DELAY (default 28'h07FFFFF).
- With the macro: on landing the block enters a LAND_WAIT state instead of LOCK.
  - Lateral moves stay allowed.
  - If block_down drops, the block returns to FALL.
  - After LOCK_DELAY cycles it enters LOCK.
  - HARD landing bypasses LAND_WAIT.
- Without the macro: landing enters LOCK directly.

Decomposition:
- Package piece_pkg holds:
  - typedef key_e (KEY_NONE..KEY_HARD);
  - state enum mover_state_e;
  - function gravity_period(level).
- Sub-module das_repeat handles lateral press/hold/repeat timing and outputs a one-cycle move_left/move_right strobe.

Test Plan:
- Use BASE_PERIOD=20, LEVEL_STEP=4, MIN_PERIOD=6, SOFT=5, HARD=2, DAS=10, SHIFT=3, CELL=16.
- Reset, then spawn, game_run=1, level=0 -> shape_y goes 100->116 after 20 cycles and 132 after 40. With level=5 the period is 6.
- Hold key 2 for 20 cycles from x=298, size_x=32 -> x=314 at cycle 1, 330 at cycle 11, 346 at cycle 14; stops at 378 (378+32=410).
- block_left=1 with key 1 pressed -> x unchanged; release and re-press with block_left=0 -> x decreases by 16.
- Key 4 pressed at y=100, size_y=32 -> y steps every 2 cycles to 388, lock_valid=1. Keep lock_ready=0 for 5 cycles: lock_valid held, y stable. Raise lock_ready: touchdown pulses for 1 cycle, state IDLE.
- Assert Reset mid-HARD and mid-LOCK -> outputs return to 298/100/0/0 immediately. spawn together with key 1 -> x=298, no shift.
- game_run=0 for 50 cycles mid-fall -> no position change; gravity resumes with the counter at its held value.

Source files
------------

// File: rtl/piece_pkg.sv
// Shared types and helpers for the falling-piece motion controller.
// Optional macro LOCK_DELAY_EN adds the LAND_WAIT state.
package piece_pkg;

    typedef enum logic [2:0] {
        KEY_NONE  = 3'd0,
        KEY_LEFT  = 3'd1,
        KEY_RIGHT = 3'd2,
        KEY_SOFT  = 3'd3,
        KEY_HARD  = 3'd4
    } key_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FALL,
        ST_HARD,
`ifdef LOCK_DELAY_EN
        ST_LOCK,
        ST_LAND_WAIT
`else
        ST_LOCK
`endif
    } mover_state_e;

    // Wide enough that level*step plus the floor can never wrap.
    localparam int PERIOD_W = 64;

    // Level-scaled gravity period, floored at floor_p.
    function automatic logic [PERIOD_W-1:0] gravity_period(
        input logic [3:0]          level,
        input logic [PERIOD_W-1:0] base,
        input logic [PERIOD_W-1:0] step,
        input logic [PERIOD_W-1:0] floor_p
    );
        logic [PERIOD_W-1:0] dec;
        dec = PERIOD_W'(level) * step;
        if (dec + floor_p >= base)
            return floor_p;
        return base - dec;
    endfunction

endpackage

// File: rtl/das_repeat.sv
// Lateral key press / hold / auto-repeat timing. Emits a one-cycle
// move_left_o / move_right_o strobe; blocking is decided by the caller.
module das_repeat
    import piece_pkg::*;
#(
    parameter int               CNT_W        = 28,
    parameter logic [CNT_W-1:0] DAS_DELAY    = 28'h0FFFFFF,
    parameter logic [CNT_W-1:0] SHIFT_PERIOD = 28'h00FFFFF
) (
    input  logic decis_clk,
    input  logic Reset,
    input  logic en_i,
    input  logic clr_i,
    input  key_e key_i,
    output logic move_left_o,
    output logic move_right_o
);

    key_e             key_q, key_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rep_q, rep_d;
    logic             lat_key, due;

    // Press edge fires at once; holding fires after DAS_DELAY, then every SHIFT_PERIOD.
    always_comb begin
        key_d        = key_q;
        cnt_d        = cnt_q;
        rep_d        = rep_q;
        move_left_o  = 1'b0;
        move_right_o = 1'b0;
        lat_key      = (key_i == KEY_LEFT) || (key_i == KEY_RIGHT);
        due          = rep_q ? (cnt_q >= SHIFT_PERIOD - CNT_W'(1))
                             : (cnt_q >= DAS_DELAY - CNT_W'(1));
        if (clr_i) begin
            key_d = key_i;
            cnt_d = '0;
            rep_d = 1'b0;
        end else if (en_i) begin
            key_d = key_i;
            if (lat_key && key_i != key_q) begin
                move_left_o  = (key_i == KEY_LEFT);
                move_right_o = (key_i == KEY_RIGHT);
                cnt_d        = '0;
                rep_d        = 1'b0;
            end else if (lat_key) begin
                if (due) begin
                    move_left_o  = (key_i == KEY_LEFT);
                    move_right_o = (key_i == KEY_RIGHT);
                    cnt_d        = '0;
                    rep_d        = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_d = '0;
                rep_d = 1'b0;
            end
        end
    end

    // Key history, repeat counter and repeat-phase flag.
    always_ff @(posedge decis_clk or posedge Reset) begin
        if (Reset) begin
            key_q <= KEY_NONE;
            cnt_q <= '0;
            rep_q <= 1'b0;
        end else begin
            key_q <= key_d;
            cnt_q <= cnt_d;
            rep_q <= rep_d;
        end
    end

endmodule

// File: rtl/piece_mover.sv
// Falling-piece motion controller: gravity, lateral shift with auto-repeat,
// soft/hard drop, and valid/ready lock hand-off to the board.
// Optional macro LOCK_DELAY_EN: landing waits LOCK_DELAY cycles in LAND_WAIT.
module piece_mover
    import piece_pkg::*;
#(
    parameter int               CELL         = 16,
    parameter int               X_MIN        = 250,
    parameter int               X_MAX        = 410,
    parameter int               Y_MAX        = 420,
    parameter int               X_START      = 298,
    parameter int               Y_START      = 100,
    parameter int               CNT_W        = 28,
    parameter logic [CNT_W-1:0] BASE_PERIOD  = 28'h1FFFFFF,
    parameter logic [CNT_W-1:0] LEVEL_STEP   = 28'h0300000,
    parameter logic [CNT_W-1:0] MIN_PERIOD   = 28'h04FFFFF,
    parameter logic [CNT_W-1:0] SOFT_PERIOD  = 28'h03FFFFF,
    parameter logic [CNT_W-1:0] HARD_PERIOD  = 28'h00FFFFF,
    parameter logic [CNT_W-1:0] DAS_DELAY    = 28'h0FFFFFF,
`ifdef LOCK_DELAY_EN
    parameter logic [CNT_W-1:0] SHIFT_PERIOD = 28'h00FFFFF,
    parameter logic [CNT_W-1:0] LOCK_DELAY   = 28'h07FFFFF
`else
    parameter logic [CNT_W-1:0] SHIFT_PERIOD = 28'h00FFFFF
`endif
) (
    input  logic       Reset,
    input  logic       decis_clk,
    input  logic       game_run,
    input  logic       spawn,
    input  logic [2:0] keypress,
    input  logic [3:0] level,
    input  logic [9:0] shape_size_x,
    input  logic [9:0] shape_size_y,
    input  logic       block_left,
    input  logic       block_right,
    input  logic       block_down,
    input  logic       lock_ready,
    output logic [9:0] shape_x,
    output logic [9:0] shape_y,
    output logic       lock_valid,
    output logic       touchdown
);

    localparam int PW = CNT_W + 4;

`ifdef LOCK_DELAY_EN
    localparam mover_state_e LAND_TARGET = ST_LAND_WAIT;
`else
    localparam mover_state_e LAND_TARGET = ST_LOCK;
`endif

    mover_state_e     state_q, state_d;
    logic [9:0]       x_q, x_d, y_q, y_d, x_lat;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hard_q;
    logic [PW-1:0]    lvl_per, grav_per;
    logic             grav_due, hard_due, hard_edge, landed;
    logic             left_blk, right_blk, need_clamp, mv_left, mv_right;

    das_repeat #(
        .CNT_W        (CNT_W),
        .DAS_DELAY    (DAS_DELAY),
        .SHIFT_PERIOD (SHIFT_PERIOD)
    ) u_das (
        .decis_clk    (decis_clk),
        .Reset        (Reset),
        .en_i         (game_run),
        .clr_i        (spawn),
        .key_i        (key_e'(keypress)),
        .move_left_o  (mv_left),
        .move_right_o (mv_right)
    );

    assign lvl_per  = PW'(gravity_period(level, PERIOD_W'(BASE_PERIOD),
                                         PERIOD_W'(LEVEL_STEP), PERIOD_W'(MIN_PERIOD)));
    assign grav_per = (keypress == KEY_SOFT && lvl_per > PW'(SOFT_PERIOD))
                      ? PW'(SOFT_PERIOD) : lvl_per;
    // >= rather than == so a period shortened mid-count (soft drop) still fires.
    assign grav_due  = PW'(cnt_q) >= grav_per - PW'(1);
    assign hard_due  = cnt_q >= HARD_PERIOD - CNT_W'(1);
    assign hard_edge = (keypress == KEY_HARD) && !hard_q;

    assign landed     = block_down ||
                        (12'(y_q) + 12'(shape_size_y) + 12'(CELL) > 12'(Y_MAX));
    assign left_blk   = block_left || (12'(x_q) < 12'(X_MIN + CELL));
    assign right_blk  = block_right ||
                        (12'(x_q) + 12'(shape_size_x) + 12'(CELL) > 12'(X_MAX));
    assign need_clamp = 12'(x_q) + 12'(shape_size_x) > 12'(X_MAX);

    assign x_lat = (mv_left && !left_blk)   ? x_q - 10'(CELL) :
                   (mv_right && !right_blk) ? x_q + 10'(CELL) : x_q;

    assign shape_x    = x_q;
    assign shape_y    = y_q;
    assign lock_valid = (state_q == ST_LOCK);
    assign touchdown  = lock_valid && lock_ready && game_run && !spawn;

    // Next state, position and shared step counter; spawn beats everything.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        if (spawn) begin
            state_d = ST_FALL;
            x_d     = 10'(X_START);
            y_d     = 10'(Y_START);
            cnt_d   = '0;
        end else if (game_run) begin
            case (state_q)
                ST_FALL: begin
                    x_d = x_lat;
                    if (hard_edge) begin
                        state_d = ST_HARD;
                        cnt_d   = '0;
                    end else if (grav_due) begin
                        cnt_d = '0;
                        if (landed)
                            state_d = LAND_TARGET;
                        else
                            y_d = y_q + 10'(CELL);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_HARD: begin
                    if (hard_due) begin
                        cnt_d = '0;
                        if (landed)
                            state_d = ST_LOCK;
                        else
                            y_d = y_q + 10'(CELL);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_LOCK: begin
                    if (lock_ready)
                        state_d = ST_IDLE;
                end
`ifdef LOCK_DELAY_EN
                ST_LAND_WAIT: begin
                    x_d = x_lat;
                    if (!landed) begin
                        state_d = ST_FALL;
                        cnt_d   = '0;
                    end else if (cnt_q >= LOCK_DELAY - CNT_W'(1)) begin
                        state_d = ST_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`endif
                default: state_d = state_q;
            endcase
            // A shape that grew past the right wall is pulled back in.
            if (need_clamp)
                x_d = 10'(X_MAX) - shape_size_x;
        end
    end

    // State, position, counter and hard-key history registers.
    always_ff @(posedge decis_clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            x_q     <= 10'(X_START);
            y_q     <= 10'(Y_START);
            cnt_q   <= '0;
            hard_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            if (game_run || spawn)
                hard_q <= (keypress == KEY_HARD);
        end
    end

endmodule

// File: tb/tb_piece_mover.sv
// Directed bench for piece_mover with short periods so every step is countable.
module tb_piece_mover;

    logic       Reset, decis_clk, game_run, spawn;
    logic [2:0] keypress;
    logic [3:0] level;
    logic [9:0] shape_size_x, shape_size_y, shape_x, shape_y;
    logic       block_left, block_right, block_down, lock_ready;
    logic       lock_valid, touchdown;

    int nvec = 0;
    int nerr = 0;
    int cyc;

    piece_mover #(
        .CELL(16), .X_MIN(250), .X_MAX(410), .Y_MAX(420), .X_START(298), .Y_START(100),
        .CNT_W(28),
        .BASE_PERIOD(28'd20), .LEVEL_STEP(28'd4), .MIN_PERIOD(28'd6),
        .SOFT_PERIOD(28'd5), .HARD_PERIOD(28'd2),
        .DAS_DELAY(28'd10), .SHIFT_PERIOD(28'd3)
    ) dut (
        .Reset(Reset), .decis_clk(decis_clk), .game_run(game_run), .spawn(spawn),
        .keypress(keypress), .level(level),
        .shape_size_x(shape_size_x), .shape_size_y(shape_size_y),
        .block_left(block_left), .block_right(block_right), .block_down(block_down),
        .lock_ready(lock_ready),
        .shape_x(shape_x), .shape_y(shape_y),
        .lock_valid(lock_valid), .touchdown(touchdown)
    );

    initial decis_clk = 1'b0;
    always #5 decis_clk = ~decis_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge decis_clk);
        #1;
    endtask

    task automatic press(input logic [2:0] k);
        keypress = k;
        tick(1);
        keypress = 3'd0;
        tick(1);
    endtask

    task automatic wait_lock();
        cyc = 0;
        while (!lock_valid && cyc < 100) begin
            tick(1);
            cyc++;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_x"},  32'(shape_x), 298);
        chk({tag, "_y"},  32'(shape_y), 100);
        chk({tag, "_lv"}, 32'(lock_valid), 0);
        chk({tag, "_td"}, 32'(touchdown), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Reset = 1; game_run = 0; spawn = 0; keypress = 0; level = 0;
        shape_size_x = 10'd32; shape_size_y = 10'd32;
        block_left = 0; block_right = 0; block_down = 0; lock_ready = 0;
        #12;
        chk_reset_vals("reset");
        Reset = 0;
        tick(1);

        // gravity at level 0: period 20
        game_run = 1; spawn = 1; tick(1); spawn = 0;
        chk("spawn_y", 32'(shape_y), 100);
        tick(19); chk("grav19", 32'(shape_y), 100);
        tick(1);  chk("grav20", 32'(shape_y), 116);
        tick(20); chk("grav40", 32'(shape_y), 132);

        // level 5: period floors at 6
        level = 5; spawn = 1; tick(1); spawn = 0;
        tick(5); chk("lvl5_5", 32'(shape_y), 100);
        tick(1); chk("lvl5_6", 32'(shape_y), 116);
        level = 0;

        // soft drop: period 5
        spawn = 1; keypress = 3; tick(1); spawn = 0;
        tick(4); chk("soft4", 32'(shape_y), 100);
        tick(1); chk("soft5", 32'(shape_y), 116);
        keypress = 0;

        // hold right: immediate, DAS at 11, repeat every 3, wall at 378
        spawn = 1; tick(1); spawn = 0; keypress = 2;
        tick(1); chk("das1",  32'(shape_x), 314);
        tick(9); chk("das10", 32'(shape_x), 314);
        tick(1); chk("das11", 32'(shape_x), 330);
        tick(3); chk("das14", 32'(shape_x), 346);
        tick(3); chk("das17", 32'(shape_x), 362);
        tick(3); chk("das20", 32'(shape_x), 378);
        tick(6); chk("das_wall", 32'(shape_x), 378);
        keypress = 0;

        // wider shape pulled back inside the right wall
        shape_size_x = 10'd48; tick(1);
        chk("clamp", 32'(shape_x), 362);
        shape_size_x = 10'd32;

        // blocked left press dropped, clean re-press moves
        block_left = 1; keypress = 1; tick(1);
        chk("blk_left", 32'(shape_x), 362);
        keypress = 0; tick(1); block_left = 0;
        keypress = 1; tick(1);
        chk("left_ok", 32'(shape_x), 346);
        keypress = 0; tick(1);

        // walk to left wall: 330,314,298,282,266,250 then blocked
        for (int i = 0; i < 6; i++) press(3'd1);
        chk("left_250", 32'(shape_x), 250);
        press(3'd1);
        chk("left_wall", 32'(shape_x), 250);

        // spawn with key 1 held: no shift
        spawn = 1; keypress = 1; tick(1); spawn = 0;
        chk("spawn_key", 32'(shape_x), 298);
        tick(1);
        chk("spawn_key2", 32'(shape_x), 298);
        keypress = 0;

        // freeze mid-fall, counter resumes from held value
        spawn = 1; tick(1); spawn = 0;
        tick(10); game_run = 0;
        tick(50);
        chk("frz_y", 32'(shape_y), 100);
        chk("frz_x", 32'(shape_x), 298);
        game_run = 1;
        tick(9); chk("resume9",  32'(shape_y), 100);
        tick(1); chk("resume10", 32'(shape_y), 116);

        // hard drop to 388, then lock handshake
        spawn = 1; tick(1); spawn = 0;
        keypress = 4; tick(1); keypress = 0;
        tick(2); chk("hard_first", 32'(shape_y), 116);
        wait_lock();
        chk("hard_cycles", 32'(cyc), 36);
        chk("hard_y", 32'(shape_y), 388);
        chk("hard_lv", 32'(lock_valid), 1);
        tick(5);
        chk("lock_hold_lv", 32'(lock_valid), 1);
        chk("lock_hold_y",  32'(shape_y), 388);
        chk("lock_hold_td", 32'(touchdown), 0);
        lock_ready = 1; #1;
        chk("td_pulse", 32'(touchdown), 1);
        tick(1);
        chk("td_end", 32'(touchdown), 0);
        chk("idle_lv", 32'(lock_valid), 0);
        lock_ready = 0;
        tick(25);
        chk("idle_y", 32'(shape_y), 388);

        // landing on block_down in FALL at level 5
        level = 5; spawn = 1; tick(1); spawn = 0; block_down = 1;
        tick(5); chk("bd_lv5", 32'(lock_valid), 0);
        tick(1); chk("bd_lv6", 32'(lock_valid), 1);
        chk("bd_y", 32'(shape_y), 100);
        block_down = 0; level = 0;

        // reset in the middle of a hard drop
        spawn = 1; tick(1); spawn = 0;
        keypress = 2; tick(1); keypress = 4; tick(1); keypress = 0;
        tick(4);
        chk("pre_rst_x", 32'(shape_x), 314);
        Reset = 1; #1;
        chk_reset_vals("rst_hard");
        Reset = 0; tick(1);

        // reset while waiting in LOCK with ready raised
        spawn = 1; tick(1); spawn = 0;
        keypress = 4; tick(1); keypress = 0;
        wait_lock();
        chk("pre_rst_lv", 32'(lock_valid), 1);
        lock_ready = 1; Reset = 1; #1;
        chk_reset_vals("rst_lock");
        lock_ready = 0; Reset = 0; tick(1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
